// File: rtl/ninetynine_counter_mux.sv
// Multi-digit BCD up/down counter with a prescaled count step and a
// time-multiplexed seven-segment display driver.

module ninetynine_digit (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       load,
    input  logic       step,
    input  logic       up_dn,
    input  logic [3:0] load_digit,
    output logic [3:0] q,
    output logic       carry
);
    // carry doubles as borrow when counting down
    assign carry = step && (up_dn ? (q == 4'd9) : (q == 4'd0));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            q <= 4'd0;
        else if (clear)
            q <= 4'd0;
        else if (load)
            q <= (load_digit > 4'd9) ? 4'd9 : load_digit;
        else if (step)
            q <= up_dn ? ((q == 4'd9) ? 4'd0 : q + 4'd1)
                       : ((q == 4'd0) ? 4'd9 : q - 4'd1);
    end
endmodule

module ninetynine_counter_mux #(
    parameter int NUM_DIGITS = 2,
    parameter int TICK_DIV   = 25000000,
    parameter int SCAN_DIV   = 65536,
    parameter int BLANK_LZ   = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    up_dn,
    input  logic                    clear,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] load_val,
    output logic [4*NUM_DIGITS-1:0] count_bcd,
    output logic                    wrap,
    output logic [NUM_DIGITS-1:0]   seg_sel,
    output logic [7:0]              seg_out
);
    localparam int PW = $clog2(TICK_DIV);

    logic [PW-1:0]                 presc;
    logic                          tick;
    logic [NUM_DIGITS:0]           step;
    logic [NUM_DIGITS-1:0][3:0]    digit_q;

    assign tick = en && (presc == PW'(TICK_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            presc <= '0;
        else if (clear || load)
            presc <= '0;
        else if (en)
            presc <= tick ? '0 : presc + PW'(1);
    end

    // Ripple step chain: each digit steps only when all lower digits carry.
    assign step[0] = tick && !clear && !load;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            ninetynine_digit u_digit (
                .clk        (clk),
                .rst        (rst),
                .clear      (clear),
                .load       (load),
                .step       (step[gi]),
                .up_dn      (up_dn),
                .load_digit (load_val[4*gi +: 4]),
                .q          (digit_q[gi]),
                .carry      (step[gi+1])
            );
        end
    endgenerate

    assign count_bcd = digit_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            wrap <= 1'b0;
        else
            wrap <= step[NUM_DIGITS];
    end

    generate
        if (NUM_DIGITS == 1) begin : g_single
            assign seg_sel = 1'b1;
        end else begin : g_scan
            localparam int SW = $clog2(SCAN_DIV);
            logic [SW-1:0] scan_cnt;
            logic          scan_wrap;

            assign scan_wrap = (scan_cnt == SW'(SCAN_DIV - 1));

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    scan_cnt <= '0;
                    seg_sel  <= NUM_DIGITS'(1);
                end else begin
                    scan_cnt <= scan_wrap ? '0 : scan_cnt + SW'(1);
                    if (scan_wrap)
                        seg_sel <= {seg_sel[NUM_DIGITS-2:0], seg_sel[NUM_DIGITS-1]};
                end
            end
        end
    endgenerate

    function automatic logic [7:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg_decode = 8'h3F;
            4'd1:    seg_decode = 8'h06;
            4'd2:    seg_decode = 8'h5B;
            4'd3:    seg_decode = 8'h4F;
            4'd4:    seg_decode = 8'h66;
            4'd5:    seg_decode = 8'h6D;
            4'd6:    seg_decode = 8'h7D;
            4'd7:    seg_decode = 8'h07;
            4'd8:    seg_decode = 8'h7F;
            4'd9:    seg_decode = 8'h6F;
            default: seg_decode = 8'h00;
        endcase
    endfunction

    logic [3:0] sel_digit;
    logic       blank;
    logic       lz;

    // Walk from the top digit down so lz means "this digit and all above are 0".
    always_comb begin
        sel_digit = 4'd0;
        blank     = 1'b0;
        lz        = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            lz = lz && (digit_q[i] == 4'd0);
            if (seg_sel[i]) begin
                sel_digit = digit_q[i];
                blank     = (BLANK_LZ != 0) && (i != 0) && lz;
            end
        end
        seg_out = blank ? 8'h00 : seg_decode(sel_digit);
    end
endmodule

// File: tb/tb_ninetynine_counter_mux.sv
// Bench for ninetynine_counter_mux: decimal-value model checked every cycle,
// plus directed literal checks on the key count/wrap/blanking scenarios.

module tb_ninetynine_counter_mux;
    localparam int TICK = 4;
    localparam int SCAN = 2;

    logic       clk = 1'b0;
    logic       rst, en, up_dn, clear, load;
    logic [7:0] load_val;
    logic [7:0] count_a, seg_a, count_b, seg_b;
    logic       wrap_a, wrap_b;
    logic [1:0] sel_a, sel_b;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_on = 1'b0;

    always #5 clk = ~clk;

    ninetynine_counter_mux #(.NUM_DIGITS(2), .TICK_DIV(TICK), .SCAN_DIV(SCAN), .BLANK_LZ(0)) dut_a (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .clear(clear), .load(load),
        .load_val(load_val), .count_bcd(count_a), .wrap(wrap_a), .seg_sel(sel_a), .seg_out(seg_a));

    ninetynine_counter_mux #(.NUM_DIGITS(2), .TICK_DIV(TICK), .SCAN_DIV(SCAN), .BLANK_LZ(1)) dut_b (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .clear(clear), .load(load),
        .load_val(load_val), .count_bcd(count_b), .wrap(wrap_b), .seg_sel(sel_b), .seg_out(seg_b));

    // Model: count as a plain decimal 0..99, scan position from cycles since reset.
    int m_val = 0;
    int m_pre = 0;
    int m_cyc = 0;
    bit m_wrap = 1'b0;

    logic [7:0] seg_tab [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                                 8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};

    function automatic int sat_bcd(input logic [7:0] v);
        int hi, lo;
        hi = int'(v[7:4]);
        lo = int'(v[3:0]);
        if (hi > 9) hi = 9;
        if (lo > 9) lo = 9;
        return hi * 10 + lo;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_val <= 0; m_pre <= 0; m_cyc <= 0; m_wrap <= 1'b0;
        end else begin
            m_cyc  <= m_cyc + 1;
            m_wrap <= 1'b0;
            if (clear) begin
                m_val <= 0; m_pre <= 0;
            end else if (load) begin
                m_val <= sat_bcd(load_val); m_pre <= 0;
            end else if (en) begin
                if (m_pre == TICK - 1) begin
                    m_pre <= 0;
                    if (up_dn) begin
                        m_val  <= (m_val + 1) % 100;
                        m_wrap <= (m_val == 99);
                    end else begin
                        m_val  <= (m_val + 99) % 100;
                        m_wrap <= (m_val == 0);
                    end
                end else begin
                    m_pre <= m_pre + 1;
                end
            end
        end
    end

    function automatic logic [7:0] exp_bcd(input int v);
        return 8'(((v / 10) << 4) | (v % 10));
    endfunction

    function automatic int exp_pos();
        return (m_cyc / SCAN) % 2;
    endfunction

    function automatic logic [7:0] exp_seg(input bit blank_lz);
        int d;
        d = (exp_pos() == 0) ? (m_val % 10) : (m_val / 10);
        if (blank_lz && exp_pos() == 1 && m_val < 10) return 8'h00;
        return seg_tab[d];
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            chk("model_count_a", count_a, exp_bcd(m_val));
            chk("model_count_b", count_b, exp_bcd(m_val));
            chk("model_wrap_a", 8'(wrap_a), 8'(m_wrap));
            chk("model_wrap_b", 8'(wrap_b), 8'(m_wrap));
            chk("model_sel_a", 8'(sel_a), (exp_pos() == 0) ? 8'h01 : 8'h02);
            chk("model_sel_b", 8'(sel_b), (exp_pos() == 0) ? 8'h01 : 8'h02);
            chk("model_seg_a", seg_a, exp_seg(1'b0));
            chk("model_seg_b", seg_b, exp_seg(1'b1));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; up_dn = 1'b1; clear = 1'b0; load = 1'b0; load_val = 8'h00;
        cyc(1);
        chk("rst_count", count_a, 8'h00);
        chk("rst_sel", 8'(sel_a), 8'h01);
        chk("rst_wrap", 8'(wrap_a), 8'h00);
        chk("rst_seg", seg_a, 8'h3F);
        chk_on = 1'b1;

        // plain up-count, one step every 4 cycles
        rst = 1'b0; en = 1'b1; up_dn = 1'b1;
        cyc(8);  chk("up_8cyc", count_a, 8'h02);
        cyc(8);  chk("up_16cyc", count_a, 8'h04);

        // rollover 98 -> 99 -> 00
        load = 1'b1; load_val = 8'h98;
        cyc(1);  load = 1'b0; chk("load_98", count_a, 8'h98);
        cyc(4);  chk("roll_99", count_a, 8'h99); chk("roll_99_wrap", 8'(wrap_a), 8'h00);
        cyc(3);  chk("roll_hold", count_a, 8'h99);
        cyc(1);  chk("roll_00", count_a, 8'h00); chk("roll_wrap", 8'(wrap_a), 8'h01);
        cyc(1);  chk("roll_wrap_end", 8'(wrap_a), 8'h00);

        // clear beats load and restarts the prescaler
        load = 1'b1; load_val = 8'h12;
        cyc(1);  load = 1'b0; chk("load_12", count_a, 8'h12);
        cyc(2);
        clear = 1'b1; load = 1'b1; load_val = 8'h55;
        cyc(1);  clear = 1'b0; load = 1'b0; chk("clear_wins", count_a, 8'h00);
        cyc(3);  chk("clear_presc", count_a, 8'h00);
        cyc(1);  chk("clear_tick", count_a, 8'h01);

        // rollunder and saturating load
        load = 1'b1; load_val = 8'h00; up_dn = 1'b0;
        cyc(1);  load = 1'b0;
        cyc(3);  chk("dn_hold", count_a, 8'h00);
        cyc(1);  chk("dn_99", count_a, 8'h99); chk("dn_wrap", 8'(wrap_a), 8'h01);
        load = 1'b1; load_val = 8'hA7;
        cyc(1);  chk("sat_A7", count_a, 8'h97); chk("sat_wrap", 8'(wrap_a), 8'h00);
        load_val = 8'hFF;
        cyc(1);  chk("sat_FF", count_a, 8'h99);
        load = 1'b0; en = 1'b0;

        // leading-zero blanking
        load = 1'b1; load_val = 8'h05;
        cyc(1);  load = 1'b0;
        for (int k = 0; k < 2; k++) begin
            chk("blank_05", seg_b, (exp_pos() == 1) ? 8'h00 : 8'h6D);
            cyc(1);
        end
        load = 1'b1; load_val = 8'h00;
        cyc(1);  load = 1'b0;
        for (int k = 0; k < 2; k++) begin
            chk("blank_00", seg_b, (exp_pos() == 1) ? 8'h00 : 8'h3F);
            cyc(1);
        end
        load = 1'b1; load_val = 8'h50;
        cyc(1);  load = 1'b0;
        for (int k = 0; k < 2; k++) begin
            chk("blank_50", seg_b, (exp_pos() == 1) ? 8'h6D : 8'h3F);
            cyc(1);
        end

        // async reset mid-count at 37
        en = 1'b1; up_dn = 1'b1; load = 1'b1; load_val = 8'h37;
        cyc(1);  load = 1'b0; chk("load_37", count_a, 8'h37);
        cyc(2);
        #1 rst = 1'b1;
        #1;
        chk("async_count", count_a, 8'h00);
        chk("async_sel", 8'(sel_a), 8'h01);
        chk("async_wrap", 8'(wrap_a), 8'h00);
        chk("async_seg", seg_a, 8'h3F);
        cyc(1);  rst = 1'b0;
        cyc(3);  chk("post_rst_hold", count_a, 8'h00);
        cyc(1);  chk("post_rst_tick", count_a, 8'h01);
        cyc(4);  chk("post_rst_tick2", count_a, 8'h02);

        chk_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
